// File: rtl/time_counter.sv
// BCD time-of-day counter advanced by rising edges of tick_in; one-hot digit state, update and pulses one cycle after the edge.
// Optional alarm compare is built when TIME_COUNTER_ALARM_EN is defined; otherwise alarm is tied low.
module time_counter #(
    parameter int HOUR_MOD = 24
) (
    input  logic       in_clk,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       hold,
    input  logic       load,
    input  logic [5:0] ld_hr,
    input  logic [6:0] ld_min,
    input  logic       alarm_ld,
    input  logic       alarm_on,
    output logic [3:0] sec_u,
    output logic [2:0] sec_t,
    output logic [3:0] min_u,
    output logic [2:0] min_t,
    output logic [3:0] hr_u,
    output logic [1:0] hr_t,
    output logic       min_tick,
    output logic       hr_tick,
    output logic       day_tick,
    output logic       load_err,
    output logic       alarm
);

    localparam logic [1:0] LP_HT_MAX  = 2'(HOUR_MOD / 10);
    localparam logic [3:0] LP_HU_LIM  = 4'(HOUR_MOD % 10);
    localparam int         LP_HT_LAST = (HOUR_MOD - 1) / 10;
    localparam int         LP_HU_LAST = (HOUR_MOD - 1) % 10;

    function automatic logic [9:0] f_dec10(input logic [3:0] b);
        logic [9:0] oh;
        oh = '0;
        for (int i = 0; i < 10; i++) oh[i] = (b == 4'(i));
        return oh;
    endfunction

    function automatic logic [5:0] f_dec6(input logic [2:0] b);
        logic [5:0] oh;
        oh = '0;
        for (int i = 0; i < 6; i++) oh[i] = (b == 3'(i));
        return oh;
    endfunction

    function automatic logic [2:0] f_dec3(input logic [1:0] b);
        logic [2:0] oh;
        oh = '0;
        for (int i = 0; i < 3; i++) oh[i] = (b == 2'(i));
        return oh;
    endfunction

    function automatic logic [3:0] f_enc10(input logic [9:0] oh);
        logic [3:0] b;
        b = '0;
        for (int i = 0; i < 10; i++) if (oh[i]) b = b | 4'(i);
        return b;
    endfunction

    function automatic logic [2:0] f_enc6(input logic [5:0] oh);
        logic [2:0] b;
        b = '0;
        for (int i = 0; i < 6; i++) if (oh[i]) b = b | 3'(i);
        return b;
    endfunction

    function automatic logic [1:0] f_enc3(input logic [2:0] oh);
        logic [1:0] b;
        b = '0;
        for (int i = 0; i < 3; i++) if (oh[i]) b = b | 2'(i);
        return b;
    endfunction

    logic       r_tick_q;
    logic [9:0] r_su, r_mu, r_hu;
    logic [5:0] r_st, r_mt;
    logic [2:0] r_ht;
    logic       r_min_tick, r_hr_tick, r_day_tick, r_load_err;

    logic       w_tick, w_adv, w_st_inc, w_mu_inc, w_mt_inc, w_hr_inc;
    logic       w_day, w_hu_wrap, w_ld_ok, w_err;
    logic [9:0] w_su_n, w_mu_n, w_hu_n;
    logic [5:0] w_st_n, w_mt_n;
    logic [2:0] w_ht_n;

    // A load (valid or not) always swallows a coincident tick.
    assign w_tick    = tick_in & ~r_tick_q & ~hold;
    assign w_adv     = w_tick & ~load;
    assign w_st_inc  = w_adv & r_su[9];
    assign w_mu_inc  = w_st_inc & r_st[5];
    assign w_mt_inc  = w_mu_inc & r_mu[9];
    assign w_hr_inc  = w_mt_inc & r_mt[5];
    assign w_day     = w_hr_inc & r_ht[LP_HT_LAST] & r_hu[LP_HU_LAST];
    assign w_hu_wrap = w_hr_inc & r_hu[9];

    assign w_su_n = w_adv    ? {r_su[8:0], r_su[9]} : r_su;
    assign w_st_n = w_st_inc ? {r_st[4:0], r_st[5]} : r_st;
    assign w_mu_n = w_mu_inc ? {r_mu[8:0], r_mu[9]} : r_mu;
    assign w_mt_n = w_mt_inc ? {r_mt[4:0], r_mt[5]} : r_mt;
    assign w_hu_n = w_day ? 10'd1 : (w_hr_inc  ? {r_hu[8:0], r_hu[9]} : r_hu);
    assign w_ht_n = w_day ? 3'd1  : (w_hu_wrap ? {r_ht[1:0], r_ht[2]} : r_ht);

    assign w_ld_ok = (ld_min[6:4] <= 3'd5) && (ld_min[3:0] <= 4'd9) &&
                     (((ld_hr[5:4] < LP_HT_MAX) && (ld_hr[3:0] <= 4'd9)) ||
                      ((ld_hr[5:4] == LP_HT_MAX) && (ld_hr[3:0] < LP_HU_LIM)));

    always_ff @(posedge in_clk or negedge rst) begin
        if (!rst) begin
            r_tick_q   <= 1'b0;
            r_su       <= 10'd1;
            r_st       <= 6'd1;
            r_mu       <= 10'd1;
            r_mt       <= 6'd1;
            r_hu       <= 10'd1;
            r_ht       <= 3'd1;
            r_min_tick <= 1'b0;
            r_hr_tick  <= 1'b0;
            r_day_tick <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_tick_q   <= tick_in;
            r_min_tick <= w_mu_inc;
            r_hr_tick  <= w_hr_inc;
            r_day_tick <= w_day;
            r_load_err <= w_err;
            if (load && w_ld_ok) begin
                r_su <= 10'd1;
                r_st <= 6'd1;
                r_mu <= f_dec10(ld_min[3:0]);
                r_mt <= f_dec6(ld_min[6:4]);
                r_hu <= f_dec10(ld_hr[3:0]);
                r_ht <= f_dec3(ld_hr[5:4]);
            end else begin
                r_su <= w_su_n;
                r_st <= w_st_n;
                r_mu <= w_mu_n;
                r_mt <= w_mt_n;
                r_hu <= w_hu_n;
                r_ht <= w_ht_n;
            end
        end
    end

`ifdef TIME_COUNTER_ALARM_EN
    logic [5:0] r_al_hr;
    logic [6:0] r_al_min;
    logic       r_alarm;
    logic [5:0] w_nxt_hr;
    logic [6:0] w_nxt_min;
    logic       w_alarm_hit;

    // Compare against the post-tick time so the pulse lines up with the digit update.
    assign w_nxt_hr    = {f_enc3(w_ht_n), f_enc10(w_hu_n)};
    assign w_nxt_min   = {f_enc6(w_mt_n), f_enc10(w_mu_n)};
    assign w_alarm_hit = w_adv & alarm_on & w_su_n[0] & w_st_n[0] &
                         (w_nxt_hr == r_al_hr) & (w_nxt_min == r_al_min);
    assign w_err       = (load | alarm_ld) & ~w_ld_ok;

    always_ff @(posedge in_clk or negedge rst) begin
        if (!rst) begin
            r_al_hr  <= '0;
            r_al_min <= '0;
            r_alarm  <= 1'b0;
        end else begin
            r_alarm <= w_alarm_hit;
            if (alarm_ld && w_ld_ok) begin
                r_al_hr  <= ld_hr;
                r_al_min <= ld_min;
            end
        end
    end

    assign alarm = r_alarm;
`else
    logic w_unused_alarm;
    assign w_unused_alarm = alarm_ld ^ alarm_on;
    assign w_err          = load & ~w_ld_ok;
    assign alarm          = 1'b0;
`endif

    assign sec_u    = f_enc10(r_su);
    assign sec_t    = f_enc6(r_st);
    assign min_u    = f_enc10(r_mu);
    assign min_t    = f_enc6(r_mt);
    assign hr_u     = f_enc10(r_hu);
    assign hr_t     = f_enc3(r_ht);
    assign min_tick = r_min_tick;
    assign hr_tick  = r_hr_tick;
    assign day_tick = r_day_tick;
    assign load_err = r_load_err;

endmodule

// File: tb/tb_time_counter.sv
// Directed bench for time_counter: one 24-hour and one 12-hour instance driven with shared stimulus.
module tb_time_counter;

`ifdef TIME_COUNTER_ALARM_EN
    localparam logic EXP_AL = 1'b1;
`else
    localparam logic EXP_AL = 1'b0;
`endif

    logic       in_clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick_in = 1'b0;
    logic       hold = 1'b0;
    logic       load = 1'b0;
    logic       alarm_ld = 1'b0;
    logic       alarm_on = 1'b0;
    logic [5:0] ld_hr = '0;
    logic [6:0] ld_min = '0;

    logic [3:0] a_sec_u, a_min_u, a_hr_u, b_sec_u, b_min_u, b_hr_u;
    logic [2:0] a_sec_t, a_min_t, b_sec_t, b_min_t;
    logic [1:0] a_hr_t, b_hr_t;
    logic       a_min_tick, a_hr_tick, a_day_tick, a_load_err, a_alarm;
    logic       b_min_tick, b_hr_tick, b_day_tick, b_load_err, b_alarm;

    wire [19:0] a_t = {a_hr_t, a_hr_u, a_min_t, a_min_u, a_sec_t, a_sec_u};
    wire [19:0] b_t = {b_hr_t, b_hr_u, b_min_t, b_min_u, b_sec_t, b_sec_u};

    time_counter #(.HOUR_MOD(24)) u_dut24 (
        .in_clk(in_clk), .rst(rst), .tick_in(tick_in), .hold(hold), .load(load),
        .ld_hr(ld_hr), .ld_min(ld_min), .alarm_ld(alarm_ld), .alarm_on(alarm_on),
        .sec_u(a_sec_u), .sec_t(a_sec_t), .min_u(a_min_u), .min_t(a_min_t),
        .hr_u(a_hr_u), .hr_t(a_hr_t), .min_tick(a_min_tick), .hr_tick(a_hr_tick),
        .day_tick(a_day_tick), .load_err(a_load_err), .alarm(a_alarm)
    );

    time_counter #(.HOUR_MOD(12)) u_dut12 (
        .in_clk(in_clk), .rst(rst), .tick_in(tick_in), .hold(hold), .load(load),
        .ld_hr(ld_hr), .ld_min(ld_min), .alarm_ld(alarm_ld), .alarm_on(alarm_on),
        .sec_u(b_sec_u), .sec_t(b_sec_t), .min_u(b_min_u), .min_t(b_min_t),
        .hr_u(b_hr_u), .hr_t(b_hr_t), .min_tick(b_min_tick), .hr_tick(b_hr_tick),
        .day_tick(b_day_tick), .load_err(b_load_err), .alarm(b_alarm)
    );

    always #5 in_clk = ~in_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cnt[8] = '{default: 0};
    int base[8] = '{default: 0};

    // Pulse counters sampled mid-cycle: 0..3 for the 24-hour unit, 4..7 for the 12-hour unit.
    always @(posedge in_clk) begin
        #2;
        if (a_min_tick) cnt[0]++;
        if (a_hr_tick)  cnt[1]++;
        if (a_day_tick) cnt[2]++;
        if (a_alarm)    cnt[3]++;
        if (b_min_tick) cnt[4]++;
        if (b_hr_tick)  cnt[5]++;
        if (b_day_tick) cnt[6]++;
        if (b_alarm)    cnt[7]++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] tm(input logic [5:0] h, input logic [6:0] m, input logic [6:0] s);
        return {12'd0, h, m[6:4], m[3:0], s[6:4], s[3:0]};
    endfunction

    function automatic logic [31:0] dl(input int i);
        return 32'(cnt[i] - base[i]);
    endfunction

    task automatic mark();
        base = cnt;
    endtask

    task automatic do_tick();
        @(negedge in_clk);
        tick_in = 1'b1;
        @(negedge in_clk);
        tick_in = 1'b0;
    endtask

    task automatic do_load(input logic [5:0] h, input logic [6:0] m);
        @(negedge in_clk);
        load   = 1'b1;
        ld_hr  = h;
        ld_min = m;
        @(negedge in_clk);
        load = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge in_clk);
        chk("rst_time_a", {12'd0, a_t}, 32'd0);
        chk("rst_time_b", {12'd0, b_t}, 32'd0);
        chk("rst_pulses", {27'd0, a_min_tick, a_hr_tick, a_day_tick, a_load_err, a_alarm}, 32'd0);
        @(negedge in_clk);
        rst = 1'b1;

        mark();
        repeat (10) do_tick();
        chk("ten_ticks", {12'd0, a_t}, tm(6'h00, 7'h00, 7'h10));
        chk("ten_sec_u", {28'd0, a_sec_u}, 32'd0);
        chk("ten_sec_t", {29'd0, a_sec_t}, 32'd1);
        chk("ten_no_carry", dl(0) + dl(1) + dl(2), 32'd0);

        do_load(6'h23, 7'h59);
        chk("ld2359_time", {12'd0, a_t}, tm(6'h23, 7'h59, 7'h00));
        chk("ld2359_ok", {31'd0, a_load_err}, 32'd0);
        chk("ld2359_err12", {31'd0, b_load_err}, 32'd1);
        chk("ld2359_hold12", {12'd0, b_t}, tm(6'h00, 7'h00, 7'h10));
        @(negedge in_clk);
        chk("err_width", {31'd0, b_load_err}, 32'd0);
        mark();
        repeat (60) do_tick();
        chk("wrap24_time", {12'd0, a_t}, 32'd0);
        chk("wrap24_min", dl(0), 32'd1);
        chk("wrap24_hr", dl(1), 32'd1);
        chk("wrap24_day", dl(2), 32'd1);
        chk("b_plus60", {12'd0, b_t}, tm(6'h00, 7'h01, 7'h10));
        chk("b_plus60_min", dl(4), 32'd1);

        do_load(6'h11, 7'h59);
        chk("ld1159_b", {12'd0, b_t}, tm(6'h11, 7'h59, 7'h00));
        mark();
        repeat (60) do_tick();
        chk("wrap12_time", {12'd0, b_t}, 32'd0);
        chk("wrap12_day", dl(6), 32'd1);
        chk("wrap12_hr", dl(5), 32'd1);
        chk("noon24_time", {12'd0, a_t}, tm(6'h12, 7'h00, 7'h00));
        chk("noon24_day", dl(2), 32'd0);

        do_load(6'h12, 7'h00);
        chk("hr12_err", {31'd0, b_load_err}, 32'd1);
        chk("hr12_same", {12'd0, b_t}, 32'd0);
        chk("hr12_ok24", {31'd0, a_load_err}, 32'd0);
        do_load(6'h24, 7'h00);
        chk("hr24_err", {31'd0, a_load_err}, 32'd1);
        chk("hr24_same", {12'd0, a_t}, tm(6'h12, 7'h00, 7'h00));
        do_load(6'h01, 7'h60);
        chk("mint6_err", {31'd0, a_load_err}, 32'd1);
        chk("mint6_same", {12'd0, a_t}, tm(6'h12, 7'h00, 7'h00));
        @(negedge in_clk);
        chk("mint6_width", {31'd0, a_load_err}, 32'd0);
        do_load(6'h01, 7'h0A);
        chk("minuA_err", {31'd0, a_load_err}, 32'd1);
        chk("minuA_same", {12'd0, a_t}, tm(6'h12, 7'h00, 7'h00));

        mark();
        @(negedge in_clk);
        tick_in = 1'b1;
        load    = 1'b1;
        ld_hr   = 6'h05;
        ld_min  = 7'h30;
        @(negedge in_clk);
        load = 1'b0;
        chk("ldtick_time", {12'd0, a_t}, tm(6'h05, 7'h30, 7'h00));
        tick_in = 1'b0;
        @(negedge in_clk);
        chk("ldtick_after", {12'd0, a_t}, tm(6'h05, 7'h30, 7'h00));
        chk("ldtick_pulse", dl(0) + dl(1) + dl(2), 32'd0);

        hold = 1'b1;
        repeat (5) do_tick();
        hold = 1'b0;
        @(negedge in_clk);
        chk("hold_frozen", {12'd0, a_t}, tm(6'h05, 7'h30, 7'h00));

        @(negedge in_clk);
        tick_in = 1'b1;
        repeat (20) @(negedge in_clk);
        tick_in = 1'b0;
        @(negedge in_clk);
        chk("held_high", {12'd0, a_t}, tm(6'h05, 7'h30, 7'h01));

        @(negedge in_clk);
        tick_in = 1'b1;
        @(negedge in_clk);
        rst = 1'b0;
        #1;
        chk("rst_async", {12'd0, a_t}, 32'd0);
        @(negedge in_clk);
        rst = 1'b1;
        @(negedge in_clk);
        chk("rel_high_tick", {12'd0, a_t}, tm(6'h00, 7'h00, 7'h01));
        @(negedge in_clk);
        chk("rel_high_once", {12'd0, a_t}, tm(6'h00, 7'h00, 7'h01));
        tick_in = 1'b0;

        @(negedge in_clk);
        alarm_ld = 1'b1;
        load     = 1'b1;
        alarm_on = 1'b1;
        ld_hr    = 6'h07;
        ld_min   = 7'h30;
        @(negedge in_clk);
        alarm_ld = 1'b0;
        ld_min   = 7'h29;
        load     = 1'b1;
        @(negedge in_clk);
        load = 1'b0;
        chk("al_load_ok", {31'd0, a_load_err}, 32'd0);
        mark();
        repeat (59) do_tick();
        @(negedge in_clk);
        tick_in = 1'b1;
        @(negedge in_clk);
        chk("al_pulse_now", {31'd0, a_alarm}, {31'd0, EXP_AL});
        chk("al_time", {12'd0, a_t}, tm(6'h07, 7'h30, 7'h00));
        tick_in = 1'b0;
        @(negedge in_clk);
        chk("al_count_a", dl(3), {31'd0, EXP_AL});
        chk("al_count_b", dl(7), {31'd0, EXP_AL});

        alarm_on = 1'b0;
        do_load(6'h07, 7'h29);
        mark();
        repeat (60) do_tick();
        chk("al_off_count", dl(3), 32'd0);

        alarm_on = 1'b1;
        mark();
        do_load(6'h07, 7'h30);
        repeat (2) @(negedge in_clk);
        chk("al_on_load", dl(3), 32'd0);

        @(negedge in_clk);
        alarm_ld = 1'b1;
        ld_hr    = 6'h07;
        ld_min   = 7'h60;
        @(negedge in_clk);
        alarm_ld = 1'b0;
        chk("al_ld_err", {31'd0, a_load_err}, {31'd0, EXP_AL});
        chk("al_ld_same", {12'd0, a_t}, tm(6'h07, 7'h30, 7'h00));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
